// File: rtl/bus_responder_mem_io_pkg.sv
// Shared address map and timer-control layout for the data-side bus responder.
// Imported by the RTL, the core's test program and the bench.
package bus_responder_mem_io_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic [DATA_W-1:0] ADDR_PORT_OUT = 8'hF0;
   localparam logic [DATA_W-1:0] ADDR_PORT_IN  = 8'hF1;
   localparam logic [DATA_W-1:0] ADDR_TMR_CNT  = 8'hF2;
   localparam logic [DATA_W-1:0] ADDR_TMR_CTL  = 8'hF3;
   localparam logic [DATA_W-1:0] ADDR_TMR_RLD  = 8'hF4;

   localparam int unsigned CTL_BIT_EN     = 0;
   localparam int unsigned CTL_BIT_AR     = 1;
   localparam int unsigned CTL_BIT_IRQ_EN = 6;
   localparam int unsigned CTL_BIT_OVF    = 7;

   typedef struct packed {
      logic       ovf;
      logic       irq_en;
      logic [3:0] rsvd;
      logic       auto_reload;
      logic       en;
   } tmr_ctl_t;

   function automatic tmr_ctl_t pack_ctl(input logic en, input logic ar,
                                         input logic irq_en, input logic ovf);
      tmr_ctl_t c;
      c.ovf         = ovf;
      c.irq_en      = irq_en;
      c.rsvd        = 4'b0000;
      c.auto_reload = ar;
      c.en          = en;
      return c;
   endfunction

endpackage

// File: rtl/bus_responder_mem_io_timer8.sv
// 8-bit prescaled timer: prescaler, TMR_CNT/CTL/RLD and overflow handling.
// CPU writes arrive as decoded strobes; register values are exposed for the read mux.
module bus_timer8
   import bus_responder_mem_io_pkg::*;
#(
   parameter int unsigned PRESC = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cnt_we,
   input  logic              i_ctl_we,
   input  logic              i_rld_we,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_cnt,
   output logic [DATA_W-1:0] o_ctl,
   output logic [DATA_W-1:0] o_rld,
   output logic              o_irq
);

   localparam logic [7:0] PRESC_LAST = 8'(PRESC - 1);

   logic [7:0]        r_presc;
   logic [DATA_W-1:0] r_cnt;
   logic [DATA_W-1:0] r_rld;
   logic              r_en;
   logic              r_ar;
   logic              r_irq_en;
   logic              r_ovf;

   logic     w_tick;
   logic     w_ovf_evt;
   tmr_ctl_t w_ctl;

   // A CPU write to TMR_CNT swallows a coincident tick, including its overflow.
   assign w_tick    = r_en && (r_presc == PRESC_LAST);
   assign w_ovf_evt = w_tick && (r_cnt == 8'hFF) && !i_cnt_we;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_presc <= 8'h00;
      end else if (i_ctl_we || !r_en || w_tick) begin
         r_presc <= 8'h00;
      end else begin
         r_presc <= r_presc + 8'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_cnt_we) begin
         r_cnt <= i_wdata;
      end else if (w_ovf_evt) begin
         r_cnt <= r_ar ? r_rld : 8'h00;
      end else if (w_tick) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rld <= '0;
      end else if (i_rld_we) begin
         r_rld <= i_wdata;
      end
   end

   // Control bits: writes override the one-shot disable; overflow set beats write-1-to-clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_en     <= 1'b0;
         r_ar     <= 1'b0;
         r_irq_en <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (i_ctl_we) begin
            r_en     <= i_wdata[CTL_BIT_EN];
            r_ar     <= i_wdata[CTL_BIT_AR];
            r_irq_en <= i_wdata[CTL_BIT_IRQ_EN];
         end else if (w_ovf_evt && !r_ar) begin
            r_en <= 1'b0;
         end
         if (w_ovf_evt) begin
            r_ovf <= 1'b1;
         end else if (i_ctl_we && i_wdata[CTL_BIT_OVF]) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign w_ctl = pack_ctl(r_en, r_ar, r_irq_en, r_ovf);
   assign o_cnt = r_cnt;
   assign o_ctl = w_ctl;
   assign o_rld = r_rld;
   assign o_irq = r_ovf && r_irq_en;

endmodule

// File: rtl/bus_responder_mem_io.sv
// Data-bus responder for the 8-bit micro: data RAM, output port, synchronised input port
// and prescaled timer, with a combinational read path so the core captures data in-cycle.
module bus_responder_mem_io
   import bus_responder_mem_io_pkg::*;
#(
   parameter int unsigned RAM_DEPTH = 64,
   parameter int unsigned PRESC     = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [DATA_W-1:0] Addres_Data_Bus,
   input  logic [DATA_W-1:0] DataOut_Bus,
   input  logic              LE,
   output logic [DATA_W-1:0] Datain_Bus,
   input  logic [DATA_W-1:0] Port_In,
   output logic [DATA_W-1:0] Port_Out,
   output logic              Timer_Irq
);

   logic [DATA_W-1:0] r_ram [RAM_DEPTH];
   logic [DATA_W-1:0] r_port_out;
   logic [DATA_W-1:0] r_sync1;
   logic [DATA_W-1:0] r_sync2;

   logic              w_in_ram;
   logic              w_cnt_we;
   logic              w_ctl_we;
   logic              w_rld_we;
   logic [DATA_W-1:0] w_tmr_cnt;
   logic [DATA_W-1:0] w_tmr_ctl;
   logic [DATA_W-1:0] w_tmr_rld;
   logic              w_tmr_irq;
   logic [DATA_W-1:0] w_rdata;

   assign w_in_ram = Addres_Data_Bus < 8'(RAM_DEPTH);
   assign w_cnt_we = LE && (Addres_Data_Bus == ADDR_TMR_CNT);
   assign w_ctl_we = LE && (Addres_Data_Bus == ADDR_TMR_CTL);
   assign w_rld_we = LE && (Addres_Data_Bus == ADDR_TMR_RLD);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < RAM_DEPTH; i++) begin
            r_ram[i] <= '0;
         end
      end else if (LE && w_in_ram) begin
         for (int i = 0; i < RAM_DEPTH; i++) begin
            if (Addres_Data_Bus == 8'(i)) begin
               r_ram[i] <= DataOut_Bus;
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_port_out <= '0;
      end else if (LE && (Addres_Data_Bus == ADDR_PORT_OUT)) begin
         r_port_out <= DataOut_Bus;
      end
   end

   // Two-flop synchroniser for the asynchronous input pins.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= Port_In;
         r_sync2 <= r_sync1;
      end
   end

   bus_timer8 #(
      .PRESC (PRESC)
   ) u_timer (
      .i_clk    (Clk),
      .i_rst    (Rst),
      .i_cnt_we (w_cnt_we),
      .i_ctl_we (w_ctl_we),
      .i_rld_we (w_rld_we),
      .i_wdata  (DataOut_Bus),
      .o_cnt    (w_tmr_cnt),
      .o_ctl    (w_tmr_ctl),
      .o_rld    (w_tmr_rld),
      .o_irq    (w_tmr_irq)
   );

   // Zero-latency read mux; unmapped addresses return 0x00.
   always_comb begin
      w_rdata = '0;
      if (w_in_ram) begin
         for (int i = 0; i < RAM_DEPTH; i++) begin
            if (Addres_Data_Bus == 8'(i)) begin
               w_rdata = r_ram[i];
            end
         end
      end else begin
         case (Addres_Data_Bus)
            ADDR_PORT_OUT: w_rdata = r_port_out;
            ADDR_PORT_IN:  w_rdata = r_sync2;
            ADDR_TMR_CNT:  w_rdata = w_tmr_cnt;
            ADDR_TMR_CTL:  w_rdata = w_tmr_ctl;
            ADDR_TMR_RLD:  w_rdata = w_tmr_rld;
            default:       w_rdata = '0;
         endcase
      end
   end

   assign Datain_Bus = w_rdata;
   assign Port_Out   = r_port_out;
   assign Timer_Irq  = w_tmr_irq;

endmodule

// File: tb/tb_bus_responder_mem_io.sv
// Bench for bus_responder_mem_io: behavioural model checked every cycle plus directed literal checks.
module tb_bus_responder_mem_io;
   import bus_responder_mem_io_pkg::*;

   localparam int unsigned RAM_DEPTH = 64;
   localparam int unsigned PRESC     = 4;

   logic       Clk;
   logic       Rst;
   logic [7:0] Addres_Data_Bus;
   logic [7:0] DataOut_Bus;
   logic       LE;
   logic [7:0] Datain_Bus;
   logic [7:0] Port_In;
   logic [7:0] Port_Out;
   logic       Timer_Irq;

   int n_checks = 0;
   int n_errors = 0;
   logic done = 1'b0;

   bus_responder_mem_io #(
      .RAM_DEPTH (RAM_DEPTH),
      .PRESC     (PRESC)
   ) dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .Addres_Data_Bus (Addres_Data_Bus),
      .DataOut_Bus     (DataOut_Bus),
      .LE              (LE),
      .Datain_Bus      (Datain_Bus),
      .Port_In         (Port_In),
      .Port_Out        (Port_Out),
      .Timer_Irq       (Timer_Irq)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Model state
   logic [7:0] m_ram [256];
   logic [7:0] m_port_out, m_s1, m_s2;
   logic [7:0] m_cnt, m_rld;
   int         m_presc;
   logic       m_en, m_ar, m_irq_en, m_ovf;
   logic       t_tick, t_wcnt, t_wctl, t_ovf;

   function automatic logic [7:0] m_read(input logic [7:0] a);
      if (int'(a) < RAM_DEPTH) return m_ram[a];
      case (a)
         8'hF0:   return m_port_out;
         8'hF1:   return m_s2;
         8'hF2:   return m_cnt;
         8'hF3:   return {m_ovf, m_irq_en, 4'b0000, m_ar, m_en};
         8'hF4:   return m_rld;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < 256; i++) m_ram[i] <= 8'h00;
         m_port_out <= 8'h00; m_s1 <= 8'h00; m_s2 <= 8'h00;
         m_cnt <= 8'h00; m_rld <= 8'h00; m_presc <= 0;
         m_en <= 1'b0; m_ar <= 1'b0; m_irq_en <= 1'b0; m_ovf <= 1'b0;
      end else begin
         t_tick = m_en && (m_presc == PRESC - 1);
         t_wcnt = LE && (Addres_Data_Bus == 8'hF2);
         t_wctl = LE && (Addres_Data_Bus == 8'hF3);
         t_ovf  = t_tick && (m_cnt == 8'hFF) && !t_wcnt;
         if (LE && int'(Addres_Data_Bus) < RAM_DEPTH) m_ram[Addres_Data_Bus] <= DataOut_Bus;
         if (LE && Addres_Data_Bus == 8'hF0) m_port_out <= DataOut_Bus;
         if (LE && Addres_Data_Bus == 8'hF4) m_rld <= DataOut_Bus;
         m_s1 <= Port_In;
         m_s2 <= m_s1;
         if (t_wcnt)      m_cnt <= DataOut_Bus;
         else if (t_ovf)  m_cnt <= m_ar ? m_rld : 8'h00;
         else if (t_tick) m_cnt <= 8'((int'(m_cnt) + 1) % 256);
         m_presc <= (t_wctl || !m_en) ? 0 : (m_presc + 1) % PRESC;
         if (t_wctl) begin
            m_en <= DataOut_Bus[0]; m_ar <= DataOut_Bus[1]; m_irq_en <= DataOut_Bus[6];
         end else if (t_ovf && !m_ar) begin
            m_en <= 1'b0;
         end
         if (t_ovf) m_ovf <= 1'b1;
         else if (t_wctl && DataOut_Bus[7]) m_ovf <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (!done) begin
         check("cyc_datain", Datain_Bus, m_read(Addres_Data_Bus));
         check("cyc_port_out", Port_Out, m_port_out);
         check("cyc_irq", {7'd0, Timer_Irq}, {7'd0, m_ovf && m_irq_en});
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      Addres_Data_Bus = a; DataOut_Bus = d; LE = 1'b1;
      step();
      LE = 1'b0;
   endtask

   task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string name);
      Addres_Data_Bus = a; LE = 1'b0;
      #1;
      check(name, Datain_Bus, exp);
      check({name, "_model"}, m_read(a), exp);
   endtask

   initial begin
      Rst = 1'b1; LE = 1'b0; Addres_Data_Bus = 8'h00; DataOut_Bus = 8'h00; Port_In = 8'h00;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      step();

      // Reset state
      peek(8'h00, 8'h00, "rst_ram0");
      peek(ADDR_PORT_OUT, 8'h00, "rst_port_out_rd");
      peek(ADDR_TMR_CNT, 8'h00, "rst_cnt");
      peek(ADDR_TMR_CTL, 8'h00, "rst_ctl");
      check("rst_port_out", Port_Out, 8'h00);
      check("rst_irq", {7'd0, Timer_Irq}, 8'h00);

      // RAM write, no bypass, out-of-range
      Addres_Data_Bus = 8'h05; DataOut_Bus = 8'hA5; LE = 1'b1;
      #1 check("no_bypass", Datain_Bus, 8'h00);
      step(); LE = 1'b0;
      peek(8'h05, 8'hA5, "ram_05");
      wr(8'h3F, 8'h11); peek(8'h3F, 8'h11, "ram_last");
      wr(8'h40, 8'h22); peek(8'h40, 8'h00, "ram_depth");
      wr(8'h50, 8'h77); peek(8'h50, 8'h00, "ram_hole");
      peek(8'h05, 8'hA5, "ram_05_kept");

      // Ports and unmapped I/O
      wr(ADDR_PORT_OUT, 8'h5A);
      peek(ADDR_PORT_OUT, 8'h5A, "port_out_rd");
      check("port_out_pin", Port_Out, 8'h5A);
      wr(ADDR_PORT_IN, 8'hFF); peek(ADDR_PORT_IN, 8'h00, "port_in_ro");
      wr(8'hF5, 8'h33); peek(8'hF5, 8'h00, "unmapped_f5");

      // Input synchroniser latency
      step();
      Port_In = 8'h3C;
      step(); peek(ADDR_PORT_IN, 8'h00, "sync_1edge");
      step(); peek(ADDR_PORT_IN, 8'h3C, "sync_2edge");

      // Auto-reload overflow with interrupt
      wr(ADDR_TMR_RLD, 8'hFD);
      wr(ADDR_TMR_CNT, 8'hFD);
      wr(ADDR_TMR_CTL, 8'h43);
      repeat (11) step();
      peek(ADDR_TMR_CNT, 8'hFF, "ar_pre_ovf");
      check("ar_irq_pre", {7'd0, Timer_Irq}, 8'h00);
      step();
      peek(ADDR_TMR_CNT, 8'hFD, "ar_reload");
      peek(ADDR_TMR_CTL, 8'hC3, "ar_ctl");
      check("ar_irq", {7'd0, Timer_Irq}, 8'h01);
      wr(ADDR_TMR_CTL, 8'hC3);
      peek(ADDR_TMR_CTL, 8'h43, "ovf_clear");
      check("irq_clear", {7'd0, Timer_Irq}, 8'h00);

      // One-shot overflow
      wr(ADDR_TMR_CTL, 8'h00);
      wr(ADDR_TMR_CNT, 8'hFF);
      wr(ADDR_TMR_CTL, 8'h01);
      repeat (3) step(); peek(ADDR_TMR_CNT, 8'hFF, "os_pre");
      step();
      peek(ADDR_TMR_CNT, 8'h00, "os_cnt");
      peek(ADDR_TMR_CTL, 8'h80, "os_ctl");
      wr(ADDR_TMR_CTL, 8'h80); peek(ADDR_TMR_CTL, 8'h00, "os_clear");

      // CNT write on the tick edge
      wr(ADDR_TMR_CNT, 8'h00);
      wr(ADDR_TMR_CTL, 8'h01);
      repeat (3) step();
      wr(ADDR_TMR_CNT, 8'h10);
      peek(ADDR_TMR_CNT, 8'h10, "tick_write");
      repeat (3) step(); peek(ADDR_TMR_CNT, 8'h10, "tick_write_hold");
      step(); peek(ADDR_TMR_CNT, 8'h11, "tick_after");

      // CTL write (b7=1, en=1) on the one-shot overflow edge
      wr(ADDR_TMR_CTL, 8'h00);
      wr(ADDR_TMR_CNT, 8'hFF);
      wr(ADDR_TMR_CTL, 8'h01);
      repeat (3) step();
      wr(ADDR_TMR_CTL, 8'h81);
      peek(ADDR_TMR_CTL, 8'h81, "ovf_set_wins");
      peek(ADDR_TMR_CNT, 8'h00, "ovf_cnt");

      // Async reset mid-count
      repeat (2) step();
      Rst = 1'b1;
      #1;
      peek(ADDR_TMR_CNT, 8'h00, "arst_cnt");
      peek(ADDR_TMR_CTL, 8'h00, "arst_ctl");
      peek(ADDR_TMR_RLD, 8'h00, "arst_rld");
      peek(8'h05, 8'h00, "arst_ram");
      check("arst_port_out", Port_Out, 8'h00);
      Rst = 1'b0;
      repeat (2) step();

      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
